serial_pattern_detector: RTL and testbench

- Consumes the serial bit stream produced by the D flip-flop stage, one bit per qualified clock.
- Detects a fixed PATTERN_LEN-bit sequence and emits a one-cycle registered match pulse.
- Optionally keeps a saturating count of matches.
- Sits directly downstream of the single-bit register stage, in the same clock domain.

---
 rtl/serial_pattern_detector.sv | 99 +++++++++
 tb/tb_serial_pattern_detector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts in one bit per qualified clock and pulses match on PATTERN.
// Define SERIAL_PATTERN_DETECTOR_COUNT_EN to build the saturating match counter.
//
// state   | meaning
// S_FILL  | fewer than PATTERN_LEN valid bits held since reset or restart
// S_ARMED | window is full, every valid bit is a candidate match
module serial_pattern_detector #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int                     COUNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   d,
    input  logic                   bit_valid,
    output logic                   match,
    output logic [PATTERN_LEN-1:0] window,
    output logic [COUNT_W-1:0]     match_count
);

    localparam int                FILL_W = $clog2(PATTERN_LEN + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PATTERN_LEN);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t                 state_q;
    logic [PATTERN_LEN-1:0] window_q, window_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   match_q;
    logic                   hit;

    // The compare looks at the post-shift window and post-shift fill.
    always_comb begin
        window_d = {window_q[PATTERN_LEN-2:0], d};
        fill_d   = (fill_q == FULL) ? fill_q : fill_q + FILL_W'(1);
        hit      = bit_valid && (window_d == PATTERN) && (fill_d == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FILL;
            window_q <= '0;
            fill_q   <= '0;
            match_q  <= 1'b0;
        end else begin
            match_q <= hit;
            if (bit_valid) begin
                window_q <= window_d;
                case (state_q)
                    S_FILL: begin
                        if (hit && !OVERLAP) begin
                            fill_q <= '0;
                        end else begin
                            fill_q <= fill_d;
                            if (fill_d == FULL) state_q <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (hit && !OVERLAP) begin
                            fill_q  <= '0;
                            state_q <= S_FILL;
                        end
                    end
                    default: begin
                        fill_q  <= '0;
                        state_q <= S_FILL;
                    end
                endcase
            end
        end
    end

    assign match  = match_q;
    assign window = window_q;

`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    // Saturate at all-ones rather than wrapping back to zero.
    always_comb begin
        count_d = count_q;
        if (hit && (count_q != {COUNT_W{1'b1}})) count_d = count_q + COUNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign match_count = count_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: three instances (overlap, non-overlap, 2-bit counter)
// share one stimulus stream and are checked against a history-based reference model.
module tb_serial_pattern_detector;

    localparam logic [3:0] PAT = 4'b1011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d = 1'b0;
    logic bit_valid = 1'b0;

    logic       m_ov, m_nov, m_sat;
    logic [3:0] w_ov, w_nov, w_sat;
    logic [7:0] c_ov, c_nov;
    logic [1:0] c_sat;

    always #5 clk = ~clk;

    serial_pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .d(d), .bit_valid(bit_valid),
        .match(m_ov), .window(w_ov), .match_count(c_ov));

    serial_pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .d(d), .bit_valid(bit_valid),
        .match(m_nov), .window(w_nov), .match_count(c_nov));

    serial_pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .d(d), .bit_valid(bit_valid),
        .match(m_sat), .window(w_sat), .match_count(c_sat));

    logic       act_m [3];
    logic [3:0] act_w [3];
    logic [7:0] act_c [3];
    assign act_m[0] = m_ov;  assign act_m[1] = m_nov; assign act_m[2] = m_sat;
    assign act_w[0] = w_ov;  assign act_w[1] = w_nov; assign act_w[2] = w_sat;
    assign act_c[0] = c_ov;  assign act_c[1] = c_nov; assign act_c[2] = {6'b0, c_sat};

    // Reference model: full bit history since reset plus per-instance "bits since restart".
    bit          hist[$];
    int unsigned since [3];
    int unsigned cnt   [3];
    logic        exp_m [3];
    logic [3:0]  exp_w [3];
    logic [7:0]  exp_c [3];
    bit          ovl   [3] = '{1'b1, 1'b0, 1'b1};
    int unsigned cmax  [3] = '{255, 255, 3};

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic logic [3:0] last4();
        logic [3:0] v = '0;
        for (int j = 0; j < 4; j++)
            if (hist.size() > j) v[j] = hist[hist.size() - 1 - j];
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic b);
        if (r) hist.delete();
        else if (v) hist.push_back(b);
        for (int k = 0; k < 3; k++) begin
            exp_m[k] = 1'b0;
            if (r) begin
                since[k] = 0;
                cnt[k]   = 0;
            end else if (v) begin
                since[k]++;
                if (since[k] >= 4 && last4() == PAT) begin
                    exp_m[k] = 1'b1;
                    if (cnt[k] < cmax[k]) cnt[k]++;
                    if (!ovl[k]) since[k] = 0;
                end
            end
            exp_w[k] = last4();
`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
            exp_c[k] = 8'(cnt[k]);
`else
            exp_c[k] = 8'd0;
`endif
        end
    endtask

    task automatic step(input logic r, input logic v, input logic b);
        @(negedge clk);
        rst = r; bit_valid = v; d = b;
        @(posedge clk);
        model_edge(r, v, b);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act_m[k] !== 1'b0) begin n_err++; $display("FAIL reset match[%0d]: got %b want 0", k, act_m[k]); end
            n_cmp++;
            if (act_w[k] !== 4'b0000) begin n_err++; $display("FAIL reset window[%0d]: got %b want 0000", k, act_w[k]); end
            n_cmp++;
            if (act_c[k] !== 8'd0) begin n_err++; $display("FAIL reset count[%0d]: got %0d want 0", k, act_c[k]); end
        end
    endtask

    task automatic test_single_match();
        logic bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int pulses = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1'b0, 1'b1, bits[i]);
            else       step(1'b0, 1'b0, 1'b0);
            pulses += int'(act_m[0]);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act_m[k] !== exp_m[k]) begin n_err++; $display("FAIL single match[%0d] cyc %0d: got %b want %b", k, cyc, act_m[k], exp_m[k]); end
                n_cmp++;
                if (act_w[k] !== exp_w[k]) begin n_err++; $display("FAIL single window[%0d] cyc %0d: got %b want %b", k, cyc, act_w[k], exp_w[k]); end
                n_cmp++;
                if (act_c[k] !== exp_c[k]) begin n_err++; $display("FAIL single count[%0d] cyc %0d: got %0d want %0d", k, cyc, act_c[k], exp_c[k]); end
            end
        end
        n_cmp++;
        if (pulses != 1) begin n_err++; $display("FAIL single pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_overlap();
        logic bits [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int p_ov = 0;
        int p_nov = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, bits[i]);
            p_ov  += int'(act_m[0]);
            p_nov += int'(act_m[1]);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act_m[k] !== exp_m[k]) begin n_err++; $display("FAIL overlap match[%0d] cyc %0d: got %b want %b", k, cyc, act_m[k], exp_m[k]); end
                n_cmp++;
                if (act_c[k] !== exp_c[k]) begin n_err++; $display("FAIL overlap count[%0d] cyc %0d: got %0d want %0d", k, cyc, act_c[k], exp_c[k]); end
            end
        end
        n_cmp++;
        if (p_ov != 2) begin n_err++; $display("FAIL overlap pulses_ov: got %0d want 2", p_ov); end
        n_cmp++;
        if (p_nov != 1) begin n_err++; $display("FAIL overlap pulses_nov: got %0d want 1", p_nov); end
    endtask

    task automatic test_valid_gaps();
        logic vv [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic bb [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int pulses = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, vv[i], bb[i]);
            pulses += int'(act_m[0]);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act_m[k] !== exp_m[k]) begin n_err++; $display("FAIL gaps match[%0d] cyc %0d: got %b want %b", k, cyc, act_m[k], exp_m[k]); end
                n_cmp++;
                if (act_w[k] !== exp_w[k]) begin n_err++; $display("FAIL gaps window[%0d] cyc %0d: got %b want %b", k, cyc, act_w[k], exp_w[k]); end
            end
        end
        n_cmp++;
        if (pulses != 1) begin n_err++; $display("FAIL gaps pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act_m[k] !== 1'b0) begin n_err++; $display("FAIL midrst match[%0d]: got %b want 0", k, act_m[k]); end
            n_cmp++;
            if (act_w[k] !== 4'b0001) begin n_err++; $display("FAIL midrst window[%0d]: got %b want 0001", k, act_w[k]); end
            n_cmp++;
            if (act_c[k] !== 8'd0) begin n_err++; $display("FAIL midrst count[%0d]: got %0d want 0", k, act_c[k]); end
        end
    endtask

    task automatic test_saturation();
        logic bits [16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                            1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int pulses = 0;
        logic [7:0] want_final;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, bits[i]);
            pulses += int'(act_m[2]);
            n_cmp++;
            if (act_m[2] !== exp_m[2]) begin n_err++; $display("FAIL sat match cyc %0d: got %b want %b", cyc, act_m[2], exp_m[2]); end
            n_cmp++;
            if (act_c[2] !== exp_c[2]) begin n_err++; $display("FAIL sat count cyc %0d: got %0d want %0d", cyc, act_c[2], exp_c[2]); end
        end
`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
        want_final = 8'd3;
`else
        want_final = 8'd0;
`endif
        n_cmp++;
        if (pulses != 5) begin n_err++; $display("FAIL sat pulses: got %0d want 5", pulses); end
        n_cmp++;
        if (act_c[2] !== want_final) begin n_err++; $display("FAIL sat final count: got %0d want %0d", act_c[2], want_final); end
    endtask

    task automatic test_random();
        logic r, v, b;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 75);
            b = ($urandom_range(0, 99) < 60);
            step(r, v, b);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act_m[k] !== exp_m[k]) begin n_err++; $display("FAIL rand match[%0d] cyc %0d: got %b want %b", k, cyc, act_m[k], exp_m[k]); end
                n_cmp++;
                if (act_w[k] !== exp_w[k]) begin n_err++; $display("FAIL rand window[%0d] cyc %0d: got %b want %b", k, cyc, act_w[k], exp_w[k]); end
                n_cmp++;
                if (act_c[k] !== exp_c[k]) begin n_err++; $display("FAIL rand count[%0d] cyc %0d: got %0d want %0d", k, cyc, act_c[k], exp_c[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_match();
        test_overlap();
        test_valid_gaps();
        test_reset_midstream();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
